// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-SP13 16-bit core.
//
// Contents:
//   DEF_DATA_W / DEF_REG_AW : default datapath and register-address widths
//   OP_W                    : opcode width
//   OP_*                    : 5-bit opcode constants (same encoding as the ALU Op)
//   is_jump()               : true for the unconditional J/JR/JAL/JALR group (001xx)
package wisc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;
    localparam int OP_W       = 5;

    localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OP_W-1:0] OP_J    = 5'b00100;
    localparam logic [OP_W-1:0] OP_JR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_JALR = 5'b00111;
    localparam logic [OP_W-1:0] OP_BEQZ = 5'b01100;
    localparam logic [OP_W-1:0] OP_BNEZ = 5'b01101;
    localparam logic [OP_W-1:0] OP_BLTZ = 5'b01110;
    localparam logic [OP_W-1:0] OP_BGEZ = 5'b01111;

    function automatic logic is_jump(input logic [OP_W-1:0] op);
        return (op[4:2] == 3'b001);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch/jump resolution from ALU flags. Purely combinational so it can be
// shared with branch-predictor checking logic.
//
// Ports:
//   op    in  5  opcode
//   z     in  1  ALU zero flag
//   p     in  1  ALU positive flag
//   n     in  1  ALU negative flag
//   taken out 1  control transfer is taken
module branch_cond
    import wisc_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            z,
    input  logic            p,
    input  logic            n,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQZ: taken = z;
            OP_BNEZ: taken = ~z;
            OP_BLTZ: taken = n;
            // "greater or equal to zero" is zero or strictly positive
            OP_BGEZ: taken = z | p;
            default: taken = is_jump(op);
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary of the WISC-SP13 core.
//
// Registers the ALU result, store data, link value and control bits for the
// memory stage, resolves branches/jumps from the ALU flags and issues a
// one-cycle redirect to fetch, and tracks sticky HALT and error status.
//
// Optional feature (macro EX_MEM_PERF_EN): adds saturating 16-bit counters
// perf_retired (every capture) and perf_taken (every taken capture).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ex_valid                      execute stage holds a real instruction
//   ex_op, ex_alu_out             opcode and ALU result
//   ex_z, ex_p, ex_n, ex_err      ALU flags and illegal-op indication
//   ex_target, ex_link            branch/jump target and PC+2 link value
//   ex_st_data, ex_rd             store data and destination register
//   ex_reg_wr/mem_wr/mem_rd       control bits
//   stall, flush                  hold contents / squash incoming
//   mem_*                         stage register copies (write enables gated)
//   redirect, redirect_pc         one-cycle fetch redirect and its target
//   halted, err_sticky            sticky status, cleared only by reset
//   perf_retired, perf_taken      (EX_MEM_PERF_EN only) saturating counters
module ex_mem_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_z,
    input  logic              ex_p,
    input  logic              ex_n,
    input  logic              ex_err,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] ex_link,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_wr,
    input  logic              ex_mem_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [OP_W-1:0]   mem_op,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [DATA_W-1:0] mem_link,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_wr,
    output logic              mem_mem_wr,
    output logic              mem_mem_rd,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              halted,
    output logic              err_sticky
`ifdef EX_MEM_PERF_EN
    ,
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_taken
`endif
);

    logic              w_taken;
    logic              w_cap;

    logic              r_valid;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_st_data;
    logic [DATA_W-1:0] r_link;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_wr;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic              r_redirect;
    logic [DATA_W-1:0] r_redirect_pc;
    logic              r_halted;
    logic              r_err;

    branch_cond u_branch_cond (
        .op    (ex_op),
        .z     (ex_z),
        .p     (ex_p),
        .n     (ex_n),
        .taken (w_taken)
    );

    // flush and stall already block capture here, which gives the
    // flush > stall > capture ordering; halted freezes the pipe after HALT.
    assign w_cap = ex_valid & ~flush & ~stall & ~r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_op          <= '0;
            r_alu_out     <= '0;
            r_st_data     <= '0;
            r_link        <= '0;
            r_rd          <= '0;
            r_reg_wr      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (flush) begin
                // Data registers keep stale values; the cleared valid bit
                // gates every write enable so they are harmless.
                r_valid    <= 1'b0;
                r_redirect <= 1'b0;
            end else if (stall) begin
                // Held instruction already redirected once; never again.
                r_redirect <= 1'b0;
            end else begin
                r_valid    <= w_cap;
                r_redirect <= w_cap & w_taken;
                if (w_cap) begin
                    r_op      <= ex_op;
                    r_alu_out <= ex_alu_out;
                    r_st_data <= ex_st_data;
                    r_link    <= ex_link;
                    r_rd      <= ex_rd;
                    r_reg_wr  <= ex_reg_wr;
                    r_mem_wr  <= ex_mem_wr;
                    r_mem_rd  <= ex_mem_rd;
                end
                if (w_cap && w_taken) begin
                    r_redirect_pc <= ex_target;
                end
            end

            if (w_cap && (ex_op == OP_HALT)) begin
                r_halted <= 1'b1;
            end
            if (w_cap && ex_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_valid   = r_valid;
    assign mem_op      = r_op;
    assign mem_alu_out = r_alu_out;
    assign mem_st_data = r_st_data;
    assign mem_link    = r_link;
    assign mem_rd      = r_rd;
    assign mem_reg_wr  = r_reg_wr & r_valid;
    assign mem_mem_wr  = r_mem_wr & r_valid;
    assign mem_mem_rd  = r_mem_rd & r_valid;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign halted      = r_halted;
    assign err_sticky  = r_err;

`ifdef EX_MEM_PERF_EN
    logic [15:0] r_perf_retired;
    logic [15:0] r_perf_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= '0;
            r_perf_taken   <= '0;
        end else begin
            if (w_cap && (r_perf_retired != 16'hFFFF)) begin
                r_perf_retired <= r_perf_retired + 16'd1;
            end
            if (w_cap && w_taken && (r_perf_taken != 16'hFFFF)) begin
                r_perf_taken <= r_perf_taken + 16'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_taken   = r_perf_taken;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage. Directed vectors push their
// hand-derived expected stage contents into exp_q; a monitor pops one entry
// after every rising edge and compares it with the DUT outputs.
module tb_ex_mem_stage;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;

    // control word {reg_wr, mem_wr, mem_rd}
    localparam logic [2:0] CW_NONE = 3'b000;
    localparam logic [2:0] CW_RW   = 3'b100;
    localparam logic [2:0] CW_MW   = 3'b010;
    localparam logic [2:0] CW_LD   = 3'b101;

    // flags {z, p, n}
    localparam logic [2:0] F_Z = 3'b100;
    localparam logic [2:0] F_P = 3'b010;
    localparam logic [2:0] F_N = 3'b001;
    localparam logic [2:0] F_0 = 3'b000;

    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic [15:0] alu;
        logic        z, p, n, err;
        logic [15:0] tgt, link, st;
        logic [2:0]  rd;
        logic        rw, mw, mr;
        logic        stall, flush;
    } stim_t;

    typedef struct packed {
        logic        chk_data;
        logic        valid;
        logic [4:0]  op;
        logic [15:0] alu, st, link;
        logic [2:0]  rd;
        logic        rw, mw, mr;
        logic        redir;
        logic [15:0] rpc;
        logic        halted, err;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ex_valid, ex_z, ex_p, ex_n, ex_err;
    logic [4:0]  ex_op;
    logic [15:0] ex_alu_out, ex_target, ex_link, ex_st_data;
    logic [2:0]  ex_rd;
    logic        ex_reg_wr, ex_mem_wr, ex_mem_rd, stall, flush;
    logic        mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd;
    logic [4:0]  mem_op;
    logic [15:0] mem_alu_out, mem_st_data, mem_link, redirect_pc;
    logic [2:0]  mem_rd;
    logic        redirect, halted, err_sticky;
`ifdef EX_MEM_PERF_EN
    logic [15:0] perf_retired, perf_taken;
`endif

    ex_mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .ex_alu_out  (ex_alu_out),
        .ex_z        (ex_z),
        .ex_p        (ex_p),
        .ex_n        (ex_n),
        .ex_err      (ex_err),
        .ex_target   (ex_target),
        .ex_link     (ex_link),
        .ex_st_data  (ex_st_data),
        .ex_rd       (ex_rd),
        .ex_reg_wr   (ex_reg_wr),
        .ex_mem_wr   (ex_mem_wr),
        .ex_mem_rd   (ex_mem_rd),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_op      (mem_op),
        .mem_alu_out (mem_alu_out),
        .mem_st_data (mem_st_data),
        .mem_link    (mem_link),
        .mem_rd      (mem_rd),
        .mem_reg_wr  (mem_reg_wr),
        .mem_mem_wr  (mem_mem_wr),
        .mem_mem_rd  (mem_mem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .err_sticky  (err_sticky)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_retired(perf_retired),
        .perf_taken  (perf_taken)
`endif
    );

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    exp_t last_e;
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_n   = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s vec %0d got %h want %h", name, mon_n, got, want);
        end
    endtask

    // ---------------- vector builders ----------------
    function automatic stim_t mk(input logic v, input logic [4:0] op, input logic [15:0] alu,
                                 input logic [2:0] zpn, input logic [15:0] tgt, input logic [2:0] cw);
        stim_t s;
        s.v     = v;
        s.op    = op;
        s.alu   = alu;
        {s.z, s.p, s.n} = zpn;
        s.err   = 1'b0;
        s.tgt   = tgt;
        s.link  = alu ^ 16'h5A5A;
        s.st    = ~alu;
        s.rd    = alu[2:0];
        {s.rw, s.mw, s.mr} = cw;
        s.stall = 1'b0;
        s.flush = 1'b0;
        return s;
    endfunction

    // Captured instruction: stage copies equal the presented fields.
    function automatic exp_t cap_exp(input stim_t s, input logic redir, input logic [15:0] rpc,
                                     input logic h, input logic e);
        exp_t x;
        x.chk_data = 1'b1;
        x.valid    = 1'b1;
        x.op       = s.op;
        x.alu      = s.alu;
        x.st       = s.st;
        x.link     = s.link;
        x.rd       = s.rd;
        x.rw       = s.rw;
        x.mw       = s.mw;
        x.mr       = s.mr;
        x.redir    = redir;
        x.rpc      = rpc;
        x.halted   = h;
        x.err      = e;
        return x;
    endfunction

    // Empty stage (bubble / flush / halted): data not checked, enables low.
    function automatic exp_t empty_exp(input logic [15:0] rpc, input logic h, input logic e);
        exp_t x;
        x          = '0;
        x.rpc      = rpc;
        x.halted   = h;
        x.err      = e;
        return x;
    endfunction

    function automatic exp_t hold_exp(input exp_t prev);
        exp_t x;
        x       = prev;
        x.redir = 1'b0;
        return x;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input stim_t s);
        ex_valid   = s.v;
        ex_op      = s.op;
        ex_alu_out = s.alu;
        ex_z       = s.z;
        ex_p       = s.p;
        ex_n       = s.n;
        ex_err     = s.err;
        ex_target  = s.tgt;
        ex_link    = s.link;
        ex_st_data = s.st;
        ex_rd      = s.rd;
        ex_reg_wr  = s.rw;
        ex_mem_wr  = s.mw;
        ex_mem_rd  = s.mr;
        stall      = s.stall;
        flush      = s.flush;
    endtask

    task automatic step(input stim_t s, input exp_t e);
        apply(s);
        exp_q.push_back(e);
        last_e = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cap_vec(input stim_t s, input logic redir, input logic [15:0] rpc,
                           input logic h, input logic e);
        step(s, cap_exp(s, redir, rpc, h, e));
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_valid",   16'(mem_valid),   16'h0);
        chk("rst_mem_op",      16'(mem_op),      16'h0);
        chk("rst_mem_alu_out", mem_alu_out,      16'h0);
        chk("rst_mem_st_data", mem_st_data,      16'h0);
        chk("rst_mem_link",    mem_link,         16'h0);
        chk("rst_mem_rd",      16'(mem_rd),      16'h0);
        chk("rst_enables",     16'({mem_reg_wr, mem_mem_wr, mem_mem_rd}), 16'h0);
        chk("rst_redirect",    16'(redirect),    16'h0);
        chk("rst_redirect_pc", redirect_pc,      16'h0);
        chk("rst_halted",      16'(halted),      16'h0);
        chk("rst_err_sticky",  16'(err_sticky),  16'h0);
`ifdef EX_MEM_PERF_EN
        chk("rst_perf_retired", perf_retired,    16'h0);
        chk("rst_perf_taken",   perf_taken,      16'h0);
`endif
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n++;
            chk("mem_valid",   16'(mem_valid),  16'(mon_e.valid));
            chk("mem_reg_wr",  16'(mem_reg_wr), 16'(mon_e.rw));
            chk("mem_mem_wr",  16'(mem_mem_wr), 16'(mon_e.mw));
            chk("mem_mem_rd",  16'(mem_mem_rd), 16'(mon_e.mr));
            chk("redirect",    16'(redirect),   16'(mon_e.redir));
            chk("redirect_pc", redirect_pc,     mon_e.rpc);
            chk("halted",      16'(halted),     16'(mon_e.halted));
            chk("err_sticky",  16'(err_sticky), 16'(mon_e.err));
            if (mon_e.chk_data) begin
                chk("mem_op",      16'(mem_op), 16'(mon_e.op));
                chk("mem_alu_out", mem_alu_out, mon_e.alu);
                chk("mem_st_data", mem_st_data, mon_e.st);
                chk("mem_link",    mem_link,    mon_e.link);
                chk("mem_rd",      16'(mem_rd), 16'(mon_e.rd));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        rst_n = 1'b0;
        apply(mk(1'b0, OP_ADDI, 16'h0000, F_0, 16'h0000, CW_NONE));
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // capture and branch resolution
        cap_vec(mk(1, OP_ADDI, 16'h1234, F_P, 16'h0000, CW_RW), 0, 16'h0000, 0, 0);
        cap_vec(mk(1, OP_BEQZ, 16'h0011, F_Z, 16'h0040, CW_NONE), 1, 16'h0040, 0, 0);
        step(mk(0, OP_ADDI, 16'hDEAD, F_0, 16'h0000, CW_RW), empty_exp(16'h0040, 0, 0));
        cap_vec(mk(1, OP_BEQZ, 16'h0022, F_P, 16'h0080, CW_NONE), 0, 16'h0040, 0, 0);
        cap_vec(mk(1, OP_BNEZ, 16'h0033, F_P, 16'h0100, CW_NONE), 1, 16'h0100, 0, 0);
        cap_vec(mk(1, OP_BNEZ, 16'h0034, F_Z, 16'h0110, CW_NONE), 0, 16'h0100, 0, 0);
        cap_vec(mk(1, OP_BLTZ, 16'h0044, F_N, 16'h0200, CW_NONE), 1, 16'h0200, 0, 0);
        cap_vec(mk(1, OP_BLTZ, 16'h0055, F_P, 16'h0300, CW_NONE), 0, 16'h0200, 0, 0);
        cap_vec(mk(1, OP_BGEZ, 16'h0066, F_N, 16'h0400, CW_NONE), 0, 16'h0200, 0, 0);
        cap_vec(mk(1, OP_BGEZ, 16'h0077, F_Z, 16'h0500, CW_NONE), 1, 16'h0500, 0, 0);
        cap_vec(mk(1, OP_BGEZ, 16'h0078, F_P, 16'h0600, CW_NONE), 1, 16'h0600, 0, 0);
        cap_vec(mk(1, OP_J,    16'h0001, F_0, 16'h0700, CW_NONE), 1, 16'h0700, 0, 0);
        cap_vec(mk(1, OP_JR,   16'h0002, F_0, 16'h0710, CW_NONE), 1, 16'h0710, 0, 0);
        cap_vec(mk(1, OP_JAL,  16'h0003, F_0, 16'h0720, CW_RW),   1, 16'h0720, 0, 0);
        cap_vec(mk(1, OP_JALR, 16'h0004, F_0, 16'h0730, CW_RW),   1, 16'h0730, 0, 0);
        cap_vec(mk(1, OP_ST,   16'h0008, F_Z, 16'h0800, CW_MW),   0, 16'h0730, 0, 0);
        cap_vec(mk(1, OP_LD,   16'h000A, F_Z, 16'h0810, CW_LD),   0, 16'h0730, 0, 0);

        // stall holds ADDI 0x1234, then flush beats stall
        cap_vec(mk(1, OP_ADDI, 16'h1234, F_P, 16'h0000, CW_RW), 0, 16'h0730, 0, 0);
        for (int i = 0; i < 3; i++) begin
            s = mk(1, OP_J, 16'h5555, F_0, 16'h0900, CW_RW);
            s.stall = 1'b1;
            step(s, hold_exp(last_e));
        end
        s = mk(1, OP_ADDI, 16'h4321, F_P, 16'h0000, CW_RW);
        s.stall = 1'b1;
        s.flush = 1'b1;
        step(s, empty_exp(16'h0730, 0, 0));

        // held jump never re-pulses redirect; plain flush squashes
        cap_vec(mk(1, OP_J, 16'h0009, F_0, 16'h0A00, CW_NONE), 1, 16'h0A00, 0, 0);
        for (int i = 0; i < 2; i++) begin
            s = mk(1, OP_BEQZ, 16'h0100, F_Z, 16'h0B00, CW_NONE);
            s.stall = 1'b1;
            step(s, hold_exp(last_e));
        end
        s = mk(1, OP_J, 16'h0101, F_0, 16'h0C00, CW_RW);
        s.flush = 1'b1;
        step(s, empty_exp(16'h0A00, 0, 0));

        // flushed error is not recorded; captured error is sticky
        s = mk(1, OP_ADDI, 16'h0BAD, F_P, 16'h0000, CW_RW);
        s.err = 1'b1;
        s.flush = 1'b1;
        step(s, empty_exp(16'h0A00, 0, 0));
        s.flush = 1'b0;
        cap_vec(s, 0, 16'h0A00, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(mk(0, OP_ADDI, 16'h0000, F_0, 16'h0000, CW_NONE), empty_exp(16'h0A00, 0, 1));
        end

        // HALT, then asynchronous reset while mem_valid=1 and halted=1
        cap_vec(mk(1, OP_HALT, 16'h0000, F_Z, 16'h0000, CW_NONE), 0, 16'h0A00, 1, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // HALT blocks every later capture, including a taken jump
        cap_vec(mk(1, OP_HALT, 16'h0000, F_Z, 16'h0000, CW_NONE), 0, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(mk(1, OP_ADDI, 16'h0F0F, F_P, 16'h0000, CW_RW), empty_exp(16'h0000, 1, 0));
        end
        step(mk(1, OP_J, 16'h0000, F_0, 16'h0D00, CW_NONE), empty_exp(16'h0000, 1, 0));

`ifdef EX_MEM_PERF_EN
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cap_vec(mk(1, OP_BEQZ, 16'h0001, F_Z, 16'h0040, CW_NONE), 1, 16'h0040, 0, 0);
        cap_vec(mk(1, OP_ADDI, 16'h0002, F_P, 16'h0000, CW_RW),   0, 16'h0040, 0, 0);
        cap_vec(mk(1, OP_J,    16'h0003, F_0, 16'h0080, CW_NONE), 1, 16'h0080, 0, 0);
        chk("perf_retired_3", perf_retired, 16'd3);
        chk("perf_taken_2",   perf_taken,   16'd2);
        apply(mk(1, OP_ADDI, 16'h0004, F_P, 16'h0000, CW_RW));
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("perf_retired_sat", perf_retired, 16'hFFFF);
        chk("perf_taken_hold",  perf_taken,   16'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("perf_retired_stay", perf_retired, 16'hFFFF);
`endif

        // drain the scoreboard with a bounded wait
        apply(mk(0, OP_ADDI, 16'h0000, F_0, 16'h0000, CW_NONE));
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
